// File: rtl/csr_file.sv
// Machine-mode CSR file for a single-hart RV32 core: trap/mret bookkeeping,
// interrupt enable and pending logic, and the 64-bit cycle/instret counters.
module csr_file (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [11:0] csr_addr_i,
  input  logic        csr_re_i,
  output logic [31:0] csr_rdata_o,
  input  logic        csr_we_i,
  input  logic [31:0] csr_wdata_i,
  output logic        csr_illegal_o,
  input  logic        ecall_i,
  input  logic        ebreak_i,
  input  logic        mret_i,
  input  logic        irq_take_i,
  input  logic [31:0] pc_i,
  input  logic        retire_i,
  input  logic        irq_timer_i,
  output logic        irq_pending_o,
  output logic [31:0] trap_vec_o,
  output logic [31:0] mepc_o
);

  localparam int DATA_W = 32;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [DATA_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic              mstatus_mie;
  logic              mstatus_mpie;
  logic              mie_mtie;
  logic [DATA_W-1:0] mtvec;
  logic [DATA_W-1:0] mscratch;
  logic [DATA_W-1:0] mepc;
  logic [DATA_W-1:0] mcause;
  logic [63:0]       mcycle;
  logic [63:0]       minstret;

  logic              implemented;
  logic [DATA_W-1:0] rdata_raw;
  logic              illegal;
  logic              wr_en;
  logic              trap;
  logic [DATA_W-1:0] trap_cause;

  // Address decode: read mux plus implemented-address flag.
  always_comb begin
    implemented = 1'b1;
    rdata_raw   = '0;
    case (csr_addr_i)
      A_MSTATUS:   rdata_raw = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
      A_MISA:      rdata_raw = 32'h4000_0100;
      A_MIE:       rdata_raw = {24'b0, mie_mtie, 7'b0};
      A_MTVEC:     rdata_raw = mtvec;
      A_MSCRATCH:  rdata_raw = mscratch;
      A_MEPC:      rdata_raw = mepc;
      A_MCAUSE:    rdata_raw = mcause;
      A_MIP:       rdata_raw = {24'b0, irq_timer_i, 7'b0};
      A_MCYCLE,
      A_CYCLE:     rdata_raw = mcycle[31:0];
      A_MCYCLEH,
      A_CYCLEH:    rdata_raw = mcycle[63:32];
      A_MINSTRET,
      A_INSTRET:   rdata_raw = minstret[31:0];
      A_MINSTRETH,
      A_INSTRETH:  rdata_raw = minstret[63:32];
      A_MHARTID:   rdata_raw = '0;
      default:     implemented = 1'b0;
    endcase
  end

  // Access legality, gated read data and trap source selection.
  always_comb begin
    // The top address bits 2'b11 mark the read-only CSR space.
    illegal    = (csr_re_i | csr_we_i) &
                 (~implemented | (csr_we_i & (csr_addr_i[11:10] == 2'b11)));
    wr_en      = csr_we_i & ~illegal;
    trap       = irq_take_i | ecall_i | ebreak_i;
    if (irq_take_i)   trap_cause = 32'h8000_0007;
    else if (ecall_i) trap_cause = 32'd11;
    else              trap_cause = 32'd3;
  end

  assign csr_illegal_o = illegal;
  assign csr_rdata_o   = illegal ? '0 : rdata_raw;
  assign irq_pending_o = mstatus_mie & mie_mtie & irq_timer_i;
  assign trap_vec_o    = mtvec & ALIGN_MASK;
  assign mepc_o        = mepc;

  // mstatus interrupt-enable stack: trap entry beats mret beats a CSR write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
    end else if (trap) begin
      mstatus_mpie <= mstatus_mie;
      mstatus_mie  <= 1'b0;
    end else if (mret_i) begin
      mstatus_mie  <= mstatus_mpie;
      mstatus_mpie <= 1'b1;
    end else if (wr_en && csr_addr_i == A_MSTATUS) begin
      mstatus_mie  <= csr_wdata_i[3];
      mstatus_mpie <= csr_wdata_i[7];
    end
  end

  // mepc/mcause: trap entry overrides a software write in the same cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mepc   <= '0;
      mcause <= '0;
    end else if (trap) begin
      mepc   <= pc_i & ALIGN_MASK;
      mcause <= trap_cause;
    end else if (wr_en) begin
      if (csr_addr_i == A_MEPC)   mepc   <= csr_wdata_i & ALIGN_MASK;
      if (csr_addr_i == A_MCAUSE) mcause <= csr_wdata_i;
    end
  end

  // Plain software-written registers, unaffected by traps.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mie_mtie <= 1'b0;
      mtvec    <= '0;
      mscratch <= '0;
    end else if (wr_en) begin
      if (csr_addr_i == A_MIE)      mie_mtie <= csr_wdata_i[7];
      if (csr_addr_i == A_MTVEC)    mtvec    <= csr_wdata_i & ALIGN_MASK;
      if (csr_addr_i == A_MSCRATCH) mscratch <= csr_wdata_i;
    end
  end

  // Cycle counter: a half-write loads that half only and skips this increment.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                 mcycle        <= '0;
    else if (wr_en && csr_addr_i == A_MCYCLE)     mcycle[31:0]  <= csr_wdata_i;
    else if (wr_en && csr_addr_i == A_MCYCLEH)    mcycle[63:32] <= csr_wdata_i;
    else                                          mcycle        <= mcycle + 64'd1;
  end

  // Retired-instruction counter, same write semantics as the cycle counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                 minstret        <= '0;
    else if (wr_en && csr_addr_i == A_MINSTRET)   minstret[31:0]  <= csr_wdata_i;
    else if (wr_en && csr_addr_i == A_MINSTRETH)  minstret[63:32] <= csr_wdata_i;
    else if (retire_i)                            minstret        <= minstret + 64'd1;
  end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-002 rst_n_i  input  1  asynchronous, active-low reset.
REQ-003 csr_addr_i  input  12  CSR address from the decoder, taken from inst[31:20].
REQ-004 csr_re_i  input  1  CSR access in progress, driven by the decoder's csr_used.
REQ-005 csr_rdata_o  output  32  combinational read data, fed to the decoder's csr_reg_i.
REQ-006 csr_we_i  input  1  write strobe at retire.
REQ-007 csr_wdata_i  input  32  final write value, already computed by the ALU for RW/RS/RC.
REQ-008 csr_illegal_o  output  1  combinational; unimplemented address, or write to a read-only address.
REQ-009 ecall_i, ebreak_i, mret_i, irq_take_i  input  1 each  retire-stage events.
REQ-010 pc_i  input  32  PC of the trapping or retiring instruction.
REQ-011 retire_i  input  1  one instruction retired this cycle.
REQ-012 irq_timer_i  input  1  level-sensitive machine timer interrupt line.
REQ-013 irq_pending_o  output  1  equals mstatus.MIE & mie.MTIE & irq_timer_i.
REQ-014 trap_vec_o  output  32  equals {mtvec[31:2],2'b00}.
REQ-015 mepc_o  output  32  current mepc, used as the mret target.

Function
REQ-016 Implemented CSRs: mstatus 0x300, misa 0x301, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, cycle/cycleh 0xC00/0xC80, instret/instreth 0xC02/0xC82, mhartid 0xF14.
REQ-017 mstatus field rules:
- MIE = bit 3, MPIE = bit 7, both writable.
- MPP = [12:11], reads 2'b11.
- All other bits read 0.
REQ-018 Other read-only or masked fields:
- misa reads 32'h4000_0100.
- mhartid reads 0.
- mie: only bit 7 (MTIE) is writable; all other bits read 0.
- mip: bit 7 reflects irq_timer_i directly; all other bits read 0.
REQ-019 Write masking: mtvec[1:0] and mepc[1:0] are written as 0.
REQ-020 csr_rdata_o is combinational from csr_addr_i with zero latency, and reads 0 when the address is illegal.
REQ-021 csr_illegal_o asserts when csr_re_i or csr_we_i is high and either the address is unimplemented, or csr_we_i is high and csr_addr_i[11:10]==2'b11.
REQ-022 An illegal write changes no state.
REQ-023 mcycle is a 64-bit counter that increments every cycle and wraps from all-ones to 0.
REQ-024 minstret is a 64-bit counter that increments when retire_i is high and wraps from all-ones to 0.
REQ-025 Read-only shadows: cycle/cycleh read mcycle, and instret/instreth read minstret.
REQ-026 A write to a counter half loads that half with csr_wdata_i and suppresses that counter's increment in the same cycle; the other half is held.
REQ-027 A write into the low half does not carry into the high half.
REQ-028 Trap entry occurs on the edge where irq_take_i, ecall_i or ebreak_i is high, with these updates:
- mepc <= {pc_i[31:2],2'b00}.
- MPIE <= MIE.
- MIE <= 0.
REQ-029 mcause on trap entry: 32'h8000_0007 for irq_take_i, 11 for ecall_i, 3 for ebreak_i.
REQ-030 Trap source priority: irq_take_i > ecall_i > ebreak_i.
REQ-031 mret: MIE <= MPIE and MPIE <= 1.
REQ-032 Same-edge priority among updates: trap entry > mret > CSR write.
- A lower-priority update to the same register is dropped.
- Writes to unrelated registers still complete.
REQ-033 Counters keep counting during a trap or mret cycle.

Reset
REQ-034 On rst_n_i low, regardless of the clock, the following registers become 0 immediately:
- mstatus MIE and MPIE.
- mie, mtvec, mscratch, mepc, mcause.
- mcycle, minstret.
REQ-035 During reset: irq_pending_o=0, trap_vec_o=0, mepc_o=0, and csr_rdata_o follows address decode of the reset values.
REQ-036 Reset asserted mid-operation discards any same-cycle write or trap.
REQ-037 Counting resumes on the first rising edge after rst_n_i deasserts.

Verification
REQ-038 CSR write/read: write mtvec=32'h0000_1003 -> read 0x305 returns 32'h0000_1000, and trap_vec_o=32'h0000_1000.
REQ-039 ecall entry: with MIE=1 and pc_i=32'h0000_0084, pulse ecall_i -> mepc=0x84, mcause=11, MIE=0, MPIE=1.
- Then pulse mret_i -> MIE=1, MPIE=1.
REQ-040 Timer interrupt: set MIE=1, MTIE=1, irq_timer_i=1 -> irq_pending_o=1 and mip reads 32'h80.
- Pulse irq_take_i together with ecall_i -> mcause=32'h8000_0007.
REQ-041 Counter wrap: write mcycleh=32'hFFFF_FFFF, then mcycle=32'hFFFF_FFFF -> two cycles later {mcycleh,mcycle}=64'h0000_0000_0000_0001.
REQ-042 Illegal access: write to 0xC00 or read 0x7C0 -> csr_illegal_o=1, no state change, and the read returns 0.
REQ-043 Asynchronous reset: assert rst_n_i mid-cycle while a write is pending -> all registers read 0 immediately and the write is lost.
